inv_sub_bytes_seq: RTL and testbench

- Inverse AES SubBytes unit for the decryption datapath.
- Accepts a 128-bit state and replaces every byte with its FIPS-197 inverse S-box value. Throughput is LANES bytes per clock.
- Returns the result through a valid/ready handshake.
- Sits between InvShiftRows and AddRoundKey in the decrypt round loop. It is the decrypt-side counterpart of the forward byte-substitution table.

---
 rtl/inv_sub_bytes_seq.sv | 179 +++++++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: sequential inverse AES SubBytes, LANES bytes per clock,
// valid/ready on both sides.
// Optional round-trip self check: define INV_SUB_ROUNDTRIP_CHECK_EN.
module inv_sub_bytes_seq #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy,
    output logic         err
);

    localparam int unsigned NCYC = 16 / LANES;
    localparam int unsigned CW   = $clog2(NCYC + 1);

    // Only power-of-two lane counts that divide the 16-byte state are legal
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    // FIPS-197 inverse S-box, entry 0 in the most significant byte
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = 11'(2047) - {b, 3'b000};
        return INV_SBOX[idx -: 8];
    endfunction

`ifdef INV_SUB_ROUNDTRIP_CHECK_EN
    // FIPS-197 forward S-box, used only to re-encrypt freshly substituted bytes
    localparam logic [2047:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = 11'(2047) - {b, 3'b000};
        return FWD_SBOX[idx -: 8];
    endfunction
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [127:0]    buf_q, buf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      bit_off;
    logic [7:0]      old_b;
    logic [7:0]      new_b;
`ifdef INV_SUB_ROUNDTRIP_CHECK_EN
    logic            err_q;
    logic            rt_bad;
`endif

    // State, buffer and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: capture in IDLE, substitute LANES bytes in place per RUN cycle
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        bit_off = '0;
        old_b   = '0;
        new_b   = '0;
`ifdef INV_SUB_ROUNDTRIP_CHECK_EN
        rt_bad  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    buf_d   = state_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    bit_off = {4'(32'(cnt_q) * LANES + l), 3'b000};
                    old_b   = buf_q[bit_off +: 8];
                    new_b   = inv_sbox(old_b);
                    buf_d[bit_off +: 8] = new_b;
`ifdef INV_SUB_ROUNDTRIP_CHECK_EN
                    if (fwd_sbox(new_b) != old_b) begin
                        rt_bad = 1'b1;
                    end
`endif
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NCYC - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef INV_SUB_ROUNDTRIP_CHECK_EN
    // Sticky round-trip mismatch flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | rt_bad;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Handshake and status decoded straight from the state register
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign state_out = buf_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb_inv_sub_bytes_seq: vector table plus scoreboard for inv_sub_bytes_seq,
// with a lane sweep over LANES = 1, 2, 8, 16.
module tb_inv_sub_bytes_seq;

    localparam int unsigned MAIN_NCYC = 4;

    // FIPS-197 forward S-box; the inverse model is derived from it by search
    localparam logic [2047:0] FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct {
        string        name;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;
    logic         err;

    logic [3:0]   sw_in_valid;
    logic [3:0]   sw_in_ready;
    logic [127:0] sw_state_in;
    logic [3:0]   sw_out_valid;
    logic [3:0]   sw_out_ready;
    logic [127:0] sw_state_out [4];
    logic [3:0]   sw_busy;
    logic [3:0]   sw_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    logic [127:0] exp_q [$];
    vec_t vecs [6];

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.LANES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy),
        .err       (err)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int unsigned SW_L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        inv_sub_bytes_seq #(.LANES(SW_L)) u_sw (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (sw_in_valid[g]),
            .in_ready  (sw_in_ready[g]),
            .state_in  (sw_state_in),
            .out_valid (sw_out_valid[g]),
            .out_ready (sw_out_ready[g]),
            .state_out (sw_state_out[g]),
            .busy      (sw_busy[g]),
            .err       (sw_err[g])
        );
    end

    function automatic logic [7:0] fwd(input logic [7:0] b);
        logic [10:0] idx;
        idx = 11'(2047) - {b, 3'b000};
        return FWD[idx -: 8];
    endfunction

    function automatic logic [7:0] inv_model(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 256; i++) begin
            if (fwd(8'(i)) == b) r = 8'(i);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_block(input logic [127:0] blk);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_model(blk[8*i +: 8]);
        return r;
    endfunction

    function automatic int unsigned sw_lanes(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: a transfer happens on the edge after a negedge with valid & ready
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: unexpected output %h", state_out);
            end else begin
                chk("scoreboard data", state_out, exp_q.pop_front());
            end
        end
    end

    // Offer a block, wait for acceptance, push expectation, measure latency
    task automatic send_block(input logic [127:0] din, input logic [127:0] exp, input string name);
        int  lat;
        bit  ok;
        @(posedge clk);
        #1;
        state_in = din;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk({name, " accept timeout"}, 128'(0), 128'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        in_valid = 1'b0;
        chk({name, " busy in RUN"}, 128'(busy), 128'(1));
        chk({name, " in_ready in RUN"}, 128'(in_ready), 128'(0));
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        chk({name, " latency"}, 128'(lat), 128'(MAIN_NCYC));
    endtask

    // Hold the result for a few cycles, then take it with a one-cycle out_ready pulse
    task automatic drain(input int hold, input string name);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({name, " hold out_valid"}, 128'(out_valid), 128'(1));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, " out_valid after xfer"}, 128'(out_valid), 128'(0));
        chk({name, " in_ready after xfer"}, 128'(in_ready), 128'(1));
        chk({name, " scoreboard empty"}, 128'(exp_q.size()), 128'(0));
    endtask

    task automatic sw_run(input int g, input logic [127:0] din, input logic [127:0] exp);
        int lat;
        bit ok;
        @(posedge clk);
        #1;
        sw_state_in    = din;
        sw_in_valid[g] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sw_in_ready[g]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk($sformatf("sweep%0d accept timeout", g), 128'(0), 128'(1));
            sw_in_valid[g] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        sw_in_valid[g] = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (sw_out_valid[g]) break;
        end
        chk($sformatf("sweep lanes=%0d latency", sw_lanes(g)), 128'(lat), 128'(16 / sw_lanes(g)));
        chk($sformatf("sweep lanes=%0d data", sw_lanes(g)), sw_state_out[g], exp);
        sw_out_ready[g] = 1'b1;
        @(posedge clk);
        #1;
        sw_out_ready[g] = 1'b0;
        chk($sformatf("sweep lanes=%0d out_valid after xfer", sw_lanes(g)), 128'(sw_out_valid[g]), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r;
        logic [127:0] held;
        int           x0;

        vecs[0] = '{"all-zero", 128'h0, {16{8'h52}}};
        vecs[1] = '{"mixed", {8'h16, {13{8'hed}}, 8'h7c, 8'h63}, {8'hff, {13{8'h53}}, 8'h01, 8'h00}};
        vecs[2] = '{"all-63", {16{8'h63}}, 128'h0};
        for (int i = 3; i < 6; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            vecs[i] = '{$sformatf("random%0d", i), r, inv_block(r)};
        end

        rst          = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        state_in     = '0;
        sw_in_valid  = '0;
        sw_out_ready = '0;
        sw_state_in  = '0;
        #1;
        rst = 1'b1;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 128'(in_ready), 128'(0));
        chk("reset out_valid", 128'(out_valid), 128'(0));
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset state_out", state_out, 128'h0);
        chk("reset err", 128'(err), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle in_ready", 128'(in_ready), 128'(1));
        chk("idle out_valid", 128'(out_valid), 128'(0));
        chk("idle busy", 128'(busy), 128'(0));
        chk("idle state_out", state_out, 128'h0);

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            send_block(vecs[i].din, vecs[i].exp, vecs[i].name);
            drain(i % 3, vecs[i].name);
        end

        // Backpressure: 10 cycles in DONE with noisy inputs, then exactly one transfer
        r = {$urandom, $urandom, $urandom, $urandom};
        held = inv_block(r);
        send_block(r, held, "bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            state_in = {$urandom, $urandom, $urandom, $urandom};
            chk("bp out_valid held", 128'(out_valid), 128'(1));
            chk("bp state_out held", state_out, held);
            chk("bp in_ready low", 128'(in_ready), 128'(0));
        end
        in_valid = 1'b0;
        x0 = n_xfer;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp single transfer", 128'(n_xfer - x0), 128'(1));
        chk("bp out_valid after", 128'(out_valid), 128'(0));
        chk("bp busy after", 128'(busy), 128'(0));

        // Reset two cycles after acceptance discards the block
        @(posedge clk);
        #1;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst in_ready", 128'(in_ready), 128'(0));
        chk("midrst out_valid", 128'(out_valid), 128'(0));
        chk("midrst busy", 128'(busy), 128'(0));
        chk("midrst buffer", state_out, 128'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        x0 = n_xfer;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("midrst no output", 128'(n_xfer - x0), 128'(0));
        send_block({16{8'h63}}, 128'h0, "post-reset");
        drain(1, "post-reset");

        // Lane sweep with the all-0x63 vector and one random vector
        r = {$urandom, $urandom, $urandom, $urandom};
        held = inv_block(r);
        for (int g = 0; g < 4; g++) begin
            sw_run(g, {16{8'h63}}, 128'h0);
            sw_run(g, r, held);
        end

        chk("main err", 128'(err), 128'(0));
        chk("sweep err", 128'(sw_err), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
